// File: rtl/fft16_loads_data_if.sv
// Sample bus between the FFT input-loading stage and the stage-1 butterflies.
// The master drives the 16 samples and the ready flag; the slave drives enable.
interface fft16_loads_data_if #(
    parameter int unsigned SAMPLE_W = 16
);
    localparam int unsigned DATA_W = 2 * SAMPLE_W;

    logic              enable;
    logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic [DATA_W-1:0] x8, x9, x10, x11, x12, x13, x14, x15;
    logic              rdy_load;

    modport master (
        input  enable,
        output x0, x1, x2, x3, x4, x5, x6, x7,
        output x8, x9, x10, x11, x12, x13, x14, x15,
        output rdy_load
    );

    modport slave (
        output enable,
        input  x0, x1, x2, x3, x4, x5, x6, x7,
        input  x8, x9, x10, x11, x12, x13, x14, x15,
        input  rdy_load
    );
endinterface

// File: rtl/fft16_loads_data.sv
// FFT16 input-loading stage: copies a 16-entry constant sample table into
// 16 parallel registers, one per enabled clock, then flags rdy_load.
module fft16_loads_data #(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    fft16_loads_data_if.master  bus
);
    localparam int unsigned DATA_W  = 2 * SAMPLE_W;
    localparam int unsigned N_PTS   = 16;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rdy_q;
    logic [DATA_W-1:0]  x_q [N_PTS];

    // Table entry k: real = k*256, imag = -(k*256), both two's complement.
    function automatic logic [DATA_W-1:0] rom(input logic [CNT_W-1:0] k);
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
        re = SAMPLE_W'({k, 8'h00});
        im = SAMPLE_W'(0) - re;
        return {re, im};
    endfunction

    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            rdy_q <= 1'b0;
            for (int i = 0; i < int'(N_PTS); i++) begin
                x_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        x_q[0] <= rom(CNT_W'(0));
                        cnt    <= CNT_W'(1);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // enable low pauses in place; cnt naturally wraps to 0 on the last write
                    if (bus.enable) begin
                        x_q[cnt] <= rom(cnt);
                        cnt      <= CNT_W'(cnt + CNT_W'(1));
                        if (cnt == CNT_W'(N_PTS - 1)) begin
                            state <= DONE;
                            rdy_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // One-shot: no reload until enable has been dropped once.
                    if (!bus.enable) begin
                        rdy_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x0       = x_q[0];
    assign bus.x1       = x_q[1];
    assign bus.x2       = x_q[2];
    assign bus.x3       = x_q[3];
    assign bus.x4       = x_q[4];
    assign bus.x5       = x_q[5];
    assign bus.x6       = x_q[6];
    assign bus.x7       = x_q[7];
    assign bus.x8       = x_q[8];
    assign bus.x9       = x_q[9];
    assign bus.x10      = x_q[10];
    assign bus.x11      = x_q[11];
    assign bus.x12      = x_q[12];
    assign bus.x13      = x_q[13];
    assign bus.x14      = x_q[14];
    assign bus.x15      = x_q[15];
    assign bus.rdy_load = rdy_q;
endmodule

// File: tb/tb_fft16_loads_data.sv
// Self-checking bench for fft16_loads_data: directed scenarios plus random
// enable/reset traffic compared every cycle against a sample-list model.
module tb_fft16_loads_data;
    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    fft16_loads_data_if #(.SAMPLE_W(16)) bus ();

    fft16_loads_data #(.SAMPLE_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] xs [16];
    assign xs[0]  = bus.x0;
    assign xs[1]  = bus.x1;
    assign xs[2]  = bus.x2;
    assign xs[3]  = bus.x3;
    assign xs[4]  = bus.x4;
    assign xs[5]  = bus.x5;
    assign xs[6]  = bus.x6;
    assign xs[7]  = bus.x7;
    assign xs[8]  = bus.x8;
    assign xs[9]  = bus.x9;
    assign xs[10] = bus.x10;
    assign xs[11] = bus.x11;
    assign xs[12] = bus.x12;
    assign xs[13] = bus.x13;
    assign xs[14] = bus.x14;
    assign xs[15] = bus.x15;

    // Model: the 16 expected registers, the index of the next sample to load,
    // and whether a full set is present and awaiting enable to drop.
    logic [31:0] m_x [16];
    bit          m_rdy;
    bit          m_full;
    int          m_next;

    function automatic logic [31:0] sample(input int k);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(k * 256);
        im = 16'(-(k * 256));
        return {re, im};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_x[i] = 32'h0;
        m_rdy  = 1'b0;
        m_full = 1'b0;
        m_next = 0;
    endtask

    task automatic model_edge(input logic en);
        if (reset_n) begin
            model_clear();
        end else if (m_full) begin
            if (!en) begin
                m_full = 1'b0;
                m_rdy  = 1'b0;
            end
        end else if (en) begin
            m_x[m_next] = sample(m_next);
            m_next++;
            if (m_next == 16) begin
                m_next = 0;
                m_full = 1'b1;
                m_rdy  = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s.x%0d", ctx, i), xs[i], m_x[i]);
        end
        check($sformatf("%s.rdy_load", ctx), 32'(bus.rdy_load), 32'(m_rdy));
    endtask

    // Called at a negedge: drive enable, let one edge pass, check at the next negedge.
    task automatic step(input logic en, input string ctx);
        bus.enable = en;
        @(posedge clk);
        model_edge(en);
        @(negedge clk);
        check_all(ctx);
    endtask

    logic [31:0] snap [16];

    initial begin
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        model_clear();

        // Reset held with enable high: nothing may load.
        @(negedge clk);
        for (int c = 0; c < 10; c++) step(1'b1, "reset");
        check("reset.x15_zero", xs[15], 32'h0);

        // Basic load from reset release with enable high.
        reset_n = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step(1'b1, "basic");
            if (c == 15) check("basic.rdy_edge15", 32'(bus.rdy_load), 32'h0);
        end
        check("basic.rdy_edge16", 32'(bus.rdy_load), 32'h1);
        check("basic.x0",  xs[0],  32'h0000_0000);
        check("basic.x1",  xs[1],  32'h0100_FF00);
        check("basic.x8",  xs[8],  32'h0800_F800);
        check("basic.x15", xs[15], 32'h0F00_F100);

        // Hold in DONE, then drop for one cycle and reload.
        for (int i = 0; i < 16; i++) snap[i] = xs[i];
        for (int c = 0; c < 20; c++) step(1'b1, "hold");
        check("hold.x7_stable", xs[7], snap[7]);
        step(1'b0, "drop");
        check("drop.rdy_low", 32'(bus.rdy_load), 32'h0);
        for (int c = 1; c <= 16; c++) step(1'b1, "reload");
        check("reload.rdy", 32'(bus.rdy_load), 32'h1);
        check("reload.x15", xs[15], 32'h0F00_F100);

        // Pause: 5 enabled edges, 3 low, then the rest; rdy on edge 19 from start.
        step(1'b0, "pre_pause");
        for (int c = 1; c <= 5; c++) step(1'b1, "pause_a");
        for (int i = 0; i < 16; i++) snap[i] = xs[i];
        for (int c = 0; c < 3; c++) step(1'b0, "pause_gap");
        check("pause.x5_held", xs[5], snap[5]);
        check("pause.x15_held", xs[15], snap[15]);
        for (int c = 9; c <= 19; c++) begin
            step(1'b1, "pause_b");
            if (c == 18) check("pause.rdy_edge18", 32'(bus.rdy_load), 32'h0);
        end
        check("pause.rdy_edge19", 32'(bus.rdy_load), 32'h1);
        check("pause.x8", xs[8], 32'h0800_F800);

        // Asynchronous reset between edges after 8 loads.
        step(1'b0, "pre_mid");
        for (int c = 1; c <= 8; c++) step(1'b1, "mid");
        #2 reset_n = 1'b1;
        #1;
        model_clear();
        check_all("async_rst");
        @(negedge clk);
        check_all("async_hold");
        reset_n = 1'b0;
        for (int c = 1; c <= 16; c++) step(1'b1, "post_rst");
        check("post_rst.rdy", 32'(bus.rdy_load), 32'h1);
        check("post_rst.x1", xs[1], 32'h0100_FF00);

        // Random enable traffic with occasional synchronous-edge resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b1;
                step(1'($urandom_range(0, 1)), "rand_rst");
                reset_n = 1'b0;
            end else begin
                step(1'($urandom_range(0, 9) < 7), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
